// File: rtl/cache_tag_array.sv
// cache_tag_array: N-way set-associative tag/valid store with tree PLRU fill and flush FSM
module cache_tag_array #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int TAG_W = 24,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             rsp_valid,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    input  logic             fill,
    input  logic [SET_W-1:0] fill_set,
    input  logic [TAG_W-1:0] fill_tag,
    output logic [WAY_W-1:0] fill_way,
    input  logic             flush,
    output logic             busy
);
    localparam int LV   = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int PL_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_nx;
    logic [SET_W-1:0]  cnt;
    logic [TAG_W-1:0]  tags  [SETS][WAYS];
    logic [WAYS-1:0]   valid [SETS];
    logic [PL_W-1:0]   plru  [SETS];
    logic              start, lk, fl, hit_c, fm_c, inv_c;
    logic [WAY_W-1:0]  hw_c, fmw_c, invw_c, fw_c;

    // Tree walk: bit 0 goes to the left child, 1 to the right; heap-ordered nodes
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] p);
        int n;
        n = 0;
        for (int l = 0; l < LV; l++) n = 2 * n + 1 + int'(p[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    // Point every node on the path to way w away from it
    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WAY_W-1:0] w);
        logic [PL_W-1:0] r;
        logic            d;
        int              n;
        r = p;
        n = 0;
        for (int l = 0; l < LV; l++) begin
            d    = w[LV-1-l];
            r[n] = ~d;
            n    = 2 * n + 1 + int'(d);
        end
        return r;
    endfunction

    // A flush request takes priority over a lookup or fill in the same idle cycle
    always_comb begin
        start = flush && !busy;
        lk    = lookup_valid && !busy && !flush;
        fl    = fill && !busy && !flush;
    end

    // Tag compare and fill-way choice; descending scan makes the lowest way win
    always_comb begin
        hit_c  = 1'b0;
        hw_c   = '0;
        fm_c   = 1'b0;
        fmw_c  = '0;
        inv_c  = 1'b0;
        invw_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[lookup_set][w] && tags[lookup_set][w] == lookup_tag) begin
                hit_c = 1'b1;
                hw_c  = WAY_W'(w);
            end
            if (valid[fill_set][w] && tags[fill_set][w] == fill_tag) begin
                fm_c  = 1'b1;
                fmw_c = WAY_W'(w);
            end
            if (!valid[fill_set][w]) begin
                inv_c  = 1'b1;
                invw_c = WAY_W'(w);
            end
        end
        fw_c = fm_c ? fmw_c : inv_c ? invw_c : plru_victim(plru[fill_set]);
    end

    // Flush FSM state and sweep counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == FLUSH) ? cnt + 1'b1 : '0;
        end
    end

    // Flush runs one set per cycle and ends after the last set
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = FLUSH;
        if (state == FLUSH && cnt == SET_W'(SETS - 1)) state_nx = IDLE;
    end

    // Busy is purely a function of the FSM state
    always_comb busy = (state == FLUSH);

    // Valid and PLRU state; the fill's PLRU write follows the hit's so it wins on the same set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else if (busy) begin
            valid[cnt] <= '0;
            plru[cnt]  <= '0;
        end else begin
            if (lk && hit_c) plru[lookup_set] <= plru_touch(plru[lookup_set], hw_c);
            if (fl) begin
                valid[fill_set][fw_c] <= 1'b1;
                plru[fill_set]        <= plru_touch(plru[fill_set], fw_c);
            end
        end
    end

    // Tags carry no reset; valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (fl) tags[fill_set][fw_c] <= fill_tag;
    end

    // Registered lookup response and last fill way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            hit       <= 1'b0;
            hit_way   <= '0;
            fill_way  <= '0;
        end else begin
            rsp_valid <= lk;
            hit       <= lk && hit_c;
            hit_way   <= (lk && hit_c) ? hw_c : '0;
            if (fl) fill_way <= fw_c;
        end
    end
endmodule

// File: tb/tb_cache_tag_array.sv
// tb_cache_tag_array: directed self-checking bench for cache_tag_array (SETS=8, WAYS=2)
module tb_cache_tag_array;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [2:0]  lookup_set = '0;
    logic [23:0] lookup_tag = '0;
    logic        rsp_valid, hit;
    logic [0:0]  hit_way, fill_way;
    logic        fill = 1'b0;
    logic [2:0]  fill_set = '0;
    logic [23:0] fill_tag = '0;
    logic        flush = 1'b0;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          n;
    bit          seen;

    cache_tag_array #(.SETS(8), .WAYS(2), .TAG_W(24)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_set(lookup_set), .lookup_tag(lookup_tag),
        .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way),
        .fill(fill), .fill_set(fill_set), .fill_tag(fill_tag), .fill_way(fill_way),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic do_fill(input logic [2:0] s, input logic [23:0] t, input logic [0:0] way, input string name);
        fill = 1'b1; fill_set = s; fill_tag = t;
        step();
        fill = 1'b0;
        chk(name, 32'(fill_way), 32'(way));
    endtask

    task automatic do_lookup(input logic [2:0] s, input logic [23:0] t, input logic h, input logic [0:0] way, input string name);
        lookup_valid = 1'b1; lookup_set = s; lookup_tag = t;
        step();
        lookup_valid = 1'b0;
        chk({name, "_rsp"}, 32'(rsp_valid), 32'd1);
        chk({name, "_hit"}, 32'(hit), 32'(h));
        chk({name, "_way"}, 32'(hit_way), 32'(way));
    endtask

    task automatic wait_flush(output int cyc, output bit rsp_seen);
        cyc = 0;
        rsp_seen = 1'b0;
        while (busy && cyc < 20) begin
            step();
            cyc++;
            if (rsp_valid) rsp_seen = 1'b1;
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_way", 32'(hit_way), 32'd0);
        chk("rst_fill_way", 32'(fill_way), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();
        do_lookup(3, 24'h31, 1'b0, 1'b0, "t1_miss");
        step();
        chk("t1_idle_rsp", 32'(rsp_valid), 32'd0);
        do_fill(3, 24'h31, 1'b0, "t2_fill31");
        do_fill(3, 24'h52, 1'b1, "t2_fill52");
        do_lookup(3, 24'h52, 1'b1, 1'b1, "t2_hit52");
        do_lookup(3, 24'h31, 1'b1, 1'b0, "t3_hit31");
        do_fill(3, 24'h77, 1'b1, "t3_fill77");
        step();
        chk("t3_fill_way_hold", 32'(fill_way), 32'd1);
        do_lookup(3, 24'h52, 1'b0, 1'b0, "t3_evicted52");
        do_lookup(3, 24'h77, 1'b1, 1'b1, "t3_hit77");
        do_fill(3, 24'h31, 1'b0, "t4_refill31");
        do_lookup(3, 24'h31, 1'b1, 1'b0, "t4_hit31");
        do_lookup(3, 24'h77, 1'b1, 1'b1, "t4_keep77");
        lookup_valid = 1'b1; lookup_set = 5; lookup_tag = 24'hAA;
        fill = 1'b1; fill_set = 5; fill_tag = 24'hAA;
        step();
        lookup_valid = 1'b0; fill = 1'b0;
        chk("rbw_rsp", 32'(rsp_valid), 32'd1);
        chk("rbw_hit", 32'(hit), 32'd0);
        chk("rbw_fill_way", 32'(fill_way), 32'd0);
        do_lookup(5, 24'hAA, 1'b1, 1'b0, "rbw_after");
        do_fill(0, 24'h10, 1'b0, "set0_fill");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_busy_start", 32'(busy), 32'd1);
        lookup_valid = 1'b1; lookup_set = 3; lookup_tag = 24'h31;
        fill = 1'b1; fill_set = 4; fill_tag = 24'h66;
        wait_flush(n, seen);
        lookup_valid = 1'b0; fill = 1'b0;
        chk("t5_busy_cycles", 32'(n + 1), 32'd8 + 32'd1);
        chk("t5_rsp_while_busy", 32'(seen), 32'd0);
        chk("t5_fill_way_kept", 32'(fill_way), 32'd0);
        do_lookup(3, 24'h31, 1'b0, 1'b0, "t5_miss31");
        do_lookup(3, 24'h77, 1'b0, 1'b0, "t5_miss77");
        do_lookup(5, 24'hAA, 1'b0, 1'b0, "t5_missAA");
        do_lookup(0, 24'h10, 1'b0, 1'b0, "t5_miss10");
        do_lookup(4, 24'h66, 1'b0, 1'b0, "t5_dropped_fill");
        do_fill(2, 24'h98, 1'b0, "ff_fill98");
        do_fill(2, 24'h99, 1'b1, "ff_fill99");
        flush = 1'b1;
        fill = 1'b1; fill_set = 2; fill_tag = 24'h97;
        lookup_valid = 1'b1; lookup_set = 2; lookup_tag = 24'h98;
        step();
        flush = 1'b0; fill = 1'b0; lookup_valid = 1'b0;
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("ff_fill_way_kept", 32'(fill_way), 32'd1);
        wait_flush(n, seen);
        chk("ff_busy_cycles", 32'(n), 32'd8);
        do_lookup(2, 24'h97, 1'b0, 1'b0, "ff_miss97");
        do_fill(1, 24'h44, 1'b0, "t6_fill44");
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        chk("t6_busy_mid", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_fill_way_async", 32'(fill_way), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("t6_idle", 32'(busy), 32'd0);
        do_lookup(1, 24'h44, 1'b0, 1'b0, "t6_miss44");
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_flush(n, seen);
        chk("t6_full_flush", 32'(n), 32'd8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
